// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per BIT_EN strobe on a registered line.
module piso_shift_tx #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic             BIT_EN,
    output logic             SOUT,
    output logic             SOUTN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;
    logic               last_bit;
    logic               accept;

    // The bit at the output end of a word, given the fixed shift direction.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
    endfunction

    assign last_bit   = (state_q == ST_SHIFT) && BIT_EN && (cnt_q == CNT_LAST);
    assign LOAD_READY = !RST && ((state_q == ST_IDLE) || last_bit);
    assign accept     = LOAD_VALID && LOAD_READY;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        done_d  = last_bit;
        if (accept) begin
            // Also covers the gapless reload on the final strobe of a word.
            state_d = ST_SHIFT;
            sr_d    = DIN;
            cnt_d   = '0;
            sout_d  = first_bit(DIN);
        end else if (last_bit) begin
            state_d = ST_IDLE;
            sout_d  = IDLE_LEVEL;
        end else if ((state_q == ST_SHIFT) && BIT_EN) begin
            sr_d    = shift_word(sr_q);
            cnt_d   = cnt_q + CNT_W'(1);
            sout_d  = first_bit(shift_word(sr_q));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign SOUT  = sout_q;
    assign SOUTN = ~sout_q;
    assign BUSY  = (state_q == ST_SHIFT);
    assign DONE  = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share stimulus
// and are compared every cycle against a queue-of-pending-bits reference model.
module tb_piso_shift_tx;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         rst, vld, ben;
    logic [W-1:0] din;
    logic         rdy_m, sout_m, soutn_m, busy_m, done_m;
    logic         rdy_l, sout_l, soutn_l, busy_l, done_l;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    // Each entry is one bit slot still to appear on the line: [0] MSB-first, [1] LSB-first.
    logic [1:0] mq[$];
    logic       exp_done = 1'b0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) u_msb (
        .CLK(clk), .RST(rst), .DIN(din), .LOAD_VALID(vld), .LOAD_READY(rdy_m),
        .BIT_EN(ben), .SOUT(sout_m), .SOUTN(soutn_m), .BUSY(busy_m), .DONE(done_m)
    );

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) u_lsb (
        .CLK(clk), .RST(rst), .DIN(din), .LOAD_VALID(vld), .LOAD_READY(rdy_l),
        .BIT_EN(ben), .SOUT(sout_l), .SOUTN(soutn_l), .BUSY(busy_l), .DONE(done_l)
    );

    function automatic logic exp_ready();
        return !rst && ((mq.size() == 0) || (ben && (mq.size() == 1)));
    endfunction

    function automatic logic exp_sout(input int which);
        return (mq.size() > 0) ? mq[0][which] : IDLE;
    endfunction

    task automatic model_edge();
        logic acc;
        acc = vld && exp_ready();
        exp_done = 1'b0;
        if (rst) begin
            mq.delete();
        end else begin
            if ((mq.size() > 0) && ben) begin
                void'(mq.pop_front());
                if (mq.size() == 0) exp_done = 1'b1;
            end
            if (acc) begin
                for (int i = 0; i < W; i++) mq.push_back({din[i], din[W-1-i]});
                acc_cnt++;
            end
        end
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs.
    task automatic step(input string tag);
        logic e;
        #1;
        e = exp_ready();
        checks++;
        if (rdy_m !== e) begin
            failures++; $display("FAIL %s ready_msb got=%b exp=%b t=%0t", tag, rdy_m, e, $time);
        end
        checks++;
        if (rdy_l !== e) begin
            failures++; $display("FAIL %s ready_lsb got=%b exp=%b t=%0t", tag, rdy_l, e, $time);
        end
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (sout_m !== exp_sout(0) || soutn_m !== ~exp_sout(0)) begin
            failures++; $display("FAIL %s sout_msb got=%b/%b exp=%b t=%0t", tag, sout_m, soutn_m, exp_sout(0), $time);
        end
        checks++;
        if (sout_l !== exp_sout(1) || soutn_l !== ~exp_sout(1)) begin
            failures++; $display("FAIL %s sout_lsb got=%b/%b exp=%b t=%0t", tag, sout_l, soutn_l, exp_sout(1), $time);
        end
        checks++;
        if (busy_m !== (mq.size() > 0) || busy_l !== (mq.size() > 0)) begin
            failures++; $display("FAIL %s busy got=%b/%b exp=%b t=%0t", tag, busy_m, busy_l, (mq.size() > 0), $time);
        end
        checks++;
        if (done_m !== exp_done || done_l !== exp_done) begin
            failures++; $display("FAIL %s done got=%b/%b exp=%b t=%0t", tag, done_m, done_l, exp_done, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b1; ben = 1'b1; din = 8'h5A;
        for (int i = 0; i < 3; i++) step("reset");
        checks++;
        if (sout_m !== IDLE || busy_m !== 1'b0 || rdy_m !== 1'b0) begin
            failures++; $display("FAIL reset_state got sout=%b busy=%b rdy=%b exp sout=%b busy=0 rdy=0", sout_m, busy_m, rdy_m, IDLE);
        end
        rst = 1'b0; vld = 1'b0;
        step("reset_release");
    endtask

    task automatic test_msb_first();
        logic [W-1:0] got;
        got = '0;
        din = 8'hA5; vld = 1'b1; ben = 1'b1;
        for (int i = 0; i < W; i++) begin
            step("msb_first");
            vld = 1'b0;
            got = {got[W-2:0], sout_m};
        end
        checks++;
        if (got !== 8'hA5) begin
            failures++; $display("FAIL msb_word got=%h exp=a5", got);
        end
        step("msb_first_end");
        checks++;
        if (done_m !== 1'b1 || sout_m !== IDLE) begin
            failures++; $display("FAIL msb_cycle9 got done=%b sout=%b exp done=1 sout=%b", done_m, sout_m, IDLE);
        end
    endtask

    task automatic test_lsb_slow();
        logic [W-1:0] got;
        int dones;
        got = '0; dones = 0;
        din = 8'h81; vld = 1'b1; ben = 1'b0;
        step("lsb_slow_accept");
        vld = 1'b0;
        got[0] = sout_l;
        for (int c = 1; c <= 40; c++) begin
            ben = (c % 4 == 0);
            step("lsb_slow");
            if (done_l === 1'b1) dones++;
            if ((c % 4 == 0) && (c / 4 < W)) got[c / 4] = sout_l;
        end
        ben = 1'b1;
        checks++;
        if (got !== 8'h81) begin
            failures++; $display("FAIL lsb_word got=%h exp=81", got);
        end
        checks++;
        if (dones != 1) begin
            failures++; $display("FAIL lsb_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] got;
        int busy_cycles, start;
        logic [31:0] done_mask;
        got = '0; busy_cycles = 0; done_mask = '0; start = acc_cnt;
        din = 8'hFF; vld = 1'b1; ben = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step("back_to_back");
            if (acc_cnt == start + 1) din = 8'h00;
            if (acc_cnt == start + 2) vld = 1'b0;
            if (busy_m === 1'b1) busy_cycles++;
            if (done_m === 1'b1) done_mask[c] = 1'b1;
            if (c <= 2*W) got = {got[2*W-2:0], sout_m};
        end
        checks++;
        if (got !== 16'hFF00) begin
            failures++; $display("FAIL b2b_bits got=%h exp=ff00", got);
        end
        checks++;
        if (busy_cycles != 16) begin
            failures++; $display("FAIL b2b_busy got=%0d exp=16", busy_cycles);
        end
        checks++;
        if (done_mask !== 32'h0002_0200) begin
            failures++; $display("FAIL b2b_done_cycles got=%h exp=00020200", done_mask);
        end
    endtask

    task automatic test_gating();
        logic [W-1:0] got;
        int held;
        got = '0; held = 0;
        din = 8'h3C; vld = 1'b1; ben = 1'b0;
        step("gating_accept");
        vld = 1'b0;
        got[W-1] = sout_m;
        for (int i = 0; i < 10; i++) begin
            step("gating_hold");
            if (sout_m === 1'b0 && busy_m === 1'b1) held++;
        end
        checks++;
        if (held != 10) begin
            failures++; $display("FAIL gating_hold got=%0d exp=10", held);
        end
        ben = 1'b1;
        for (int i = W - 2; i >= 0; i--) begin
            step("gating_run");
            got[i] = sout_m;
        end
        step("gating_end");
        checks++;
        if (got !== 8'h3C) begin
            failures++; $display("FAIL gating_word got=%h exp=3c", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got, word;
        got = '0;
        din = 8'hA5; vld = 1'b1; ben = 1'b1;
        step("midrst_accept");
        vld = 1'b0;
        step("midrst_bit2");
        step("midrst_bit3");
        rst = 1'b1;
        step("midrst_reset");
        checks++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || sout_m !== IDLE) begin
            failures++; $display("FAIL midrst_state got busy=%b done=%b sout=%b exp 0 0 %b", busy_m, done_m, sout_m, IDLE);
        end
        rst = 1'b0;
        word = W'($urandom);
        din = word; vld = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            step("midrst_resend");
            vld = 1'b0;
            got[i] = sout_m;
        end
        step("midrst_end");
        checks++;
        if (got !== word) begin
            failures++; $display("FAIL midrst_word got=%h exp=%h", got, word);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(59) == 0);
            vld = $urandom_range(1);
            ben = ($urandom_range(2) != 0);
            din = W'($urandom);
            step("random");
        end
        rst = 1'b0; vld = 1'b0; ben = 1'b1;
        for (int i = 0; i < W + 2; i++) step("random_drain");
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; ben = 1'b0; din = '0;
        test_reset();
        test_msb_first();
        test_lsb_slow();
        test_back_to_back();
        test_gating();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per bit-rate strobe on a registered serial line. It also provides a complemented output. It is the transmit end paired with the team's flop-based serial capture chain, and it sits between a parallel word source and a serial link driven from the same clock domain.

## Interface
Parameters:
- WIDTH, 8: word length in bits; legal values are 2 or greater.
- LSB_FIRST, 0: 0 sends the MSB first; 1 sends the LSB first.
- IDLE_LEVEL, 1'b0: level driven on SOUT when no word is in flight.

Ports (one clock; reset is synchronous and active-high):
- CLK, in, 1: clock; all state changes on its rising edge.
- RST, in, 1: synchronous active-high reset.
- DIN, in, WIDTH: word to send; sampled on an accepted handshake.
- LOAD_VALID, in, 1: source has a word on DIN.
- LOAD_READY, out, 1: block can accept a word this cycle.
- BIT_EN, in, 1: bit-rate strobe; one serial bit is consumed per CLK cycle in which BIT_EN=1 while shifting.
- SOUT, out, 1: registered serial data.
- SOUTN, out, 1: always ~SOUT.
- BUSY, out, 1: a word is in flight (state SHIFT).
- DONE, out, 1: one-cycle pulse after the last bit of a word is consumed.

## Operation
- Internal state:
  - WIDTH-bit shift register SR.
  - Bit counter CNT, $clog2(WIDTH) bits, range 0..WIDTH-1.
  - State register with states IDLE and SHIFT.
- Accept condition: LOAD_VALID & LOAD_READY sampled at a rising edge.
- LOAD_READY (combinational):
  - 0 while RST=1.
  - Otherwise 1 when state=IDLE, or when state=SHIFT & BIT_EN & CNT=WIDTH-1 (gapless back-to-back).
  - 0 otherwise.
- IDLE:
  - SOUT=IDLE_LEVEL. BIT_EN is ignored.
  - On accept: SR<=DIN, CNT<=0, go to SHIFT, SOUT<=first bit (DIN[WIDTH-1], or DIN[0] if LSB_FIRST).
- SHIFT, BIT_EN=0: hold SR, CNT and SOUT.
- SHIFT, BIT_EN=1 and CNT<WIDTH-1:
  - Shift SR toward the output end.
  - CNT<=CNT+1.
  - SOUT<=next bit.
- SHIFT, BIT_EN=1 and CNT=WIDTH-1 (final bit consumed):
  - DONE<=1 for one cycle.
  - If an accept occurs in the same cycle: reload SR and CNT<=0, stay in SHIFT, SOUT<=first bit of the new word, with no idle cycle.
  - If no accept: go to IDLE, SOUT<=IDLE_LEVEL.
- LOAD_VALID while LOAD_READY=0 has no effect. DIN changes outside an accept are ignored.
- CNT never wraps past WIDTH-1. The shift direction is fixed by LSB_FIRST at elaboration.

## Timing
- Reset values (at the first edge with RST=1 and for every cycle RST stays high):
  - State=IDLE, CNT=0, SR=0.
  - SOUT=IDLE_LEVEL, SOUTN=~IDLE_LEVEL.
  - BUSY=0, DONE=0, LOAD_READY=0.
- Reset mid-word: the word is abandoned with no DONE pulse. SOUT returns to IDLE_LEVEL at the reset edge.
- Latency: accept at edge k puts the first bit on SOUT and sets BUSY=1 from edge k onward (visible in cycle k+1).
- Bit duration: each bit is held from its launch edge until the next edge at which BIT_EN=1 in SHIFT. Minimum one cycle (BIT_EN tied high). Word time is WIDTH strobes.
- DONE is registered: high for exactly the cycle following the edge that consumes the final bit. It is never high for two consecutive cycles unless words are one strobe long; this cannot happen because WIDTH is 2 or greater.
- BUSY: 1 from the accept edge through the final-bit edge. It stays 1 across a gapless reload.
- SOUTN is derived combinationally from the SOUT register; no extra latency.

## Test plan
- Reset check:
  - Stimulus: hold RST=1 for 3 cycles with LOAD_VALID=1.
  - Response: LOAD_READY=0, SOUT=IDLE_LEVEL, BUSY=0, DONE=0 throughout; no word is accepted.
- MSB-first word:
  - Stimulus: WIDTH=8, LSB_FIRST=0, BIT_EN=1 constant, accept DIN=8'hA5.
  - Response: SOUT=1,0,1,0,0,1,0,1 in cycles 1..8. DONE=1 and SOUT=IDLE_LEVEL in cycle 9. SOUTN is the complement every cycle.
- LSB-first word with a slow strobe:
  - Stimulus: LSB_FIRST=1, BIT_EN pulsed every 4th cycle, DIN=8'h81.
  - Response: SOUT=1,0,0,0,0,0,0,1, each bit held exactly 4 cycles. DONE pulses once.
- Gapless back-to-back:
  - Stimulus: LOAD_VALID held high with 8'hFF then 8'h00, BIT_EN=1.
  - Response: 8 ones immediately followed by 8 zeros with no IDLE_LEVEL cycle. DONE is high in cycle 9 and cycle 17. BUSY stays 1 for 16 cycles.
- Strobe gating:
  - Stimulus: BIT_EN=0 for 10 cycles after accept of 8'h3C, then 1.
  - Response: SOUT holds 0 and CNT holds 0 for those 10 cycles; the full pattern 0,0,1,1,1,1,0,0 follows.
- Reset mid-word:
  - Stimulus: assert RST after 3 bits of 8'hA5.
  - Response: the next cycle shows SOUT=IDLE_LEVEL, BUSY=0, no DONE. After release, a new accept sends a full 8 bits correctly.
